bus_drive_arbiter: RTL and testbench
====================================

// Module: bus_drive_arbiter
//
// PURPOSE
//  Round-robin arbiter sharing one tristate bus between N requesters. Each requester drives the
//  bus through its own sn74ls244 bank. The block produces the active-low g_ enables for those
//  banks and inserts dead cycles between owners so two drivers never overlap (break-before-make).
//  It sits between requesting units (ALU, sequencer, memory data path) and their bus drivers.
//
// PARAMETERS
//  N       4   number of requesters / driver banks (N >= 1)
//  DEAD    1   dead cycles with all g_ high after an owner releases (DEAD >= 1)
//  MAXHOLD 16  max consecutive grant cycles when others wait (used only with BUSARB_TIMEOUT_EN)
//  CW      5   hold counter width; must satisfy 2**CW > MAXHOLD
//
// PORTS
//  clk    in   1   rising-edge clock
//  rst    in   1   synchronous reset, active high
//  req    in   N   request, one bit per requester; held high for as long as the bus is wanted
//  gnt    out  N   one-hot grant, registered (all zero when no owner)
//  g_     out  N   active-low '244 enables, registered, always equal to ~gnt
//  busy   out  1   high in GRANT or TURN
//
// BEHAVIOUR
//  - Reset (sampled at clk edge): state=IDLE, gnt=0, g_=all 1, busy=0, ptr=0, hold_cnt=0.
//    Reset during GRANT or TURN drops every enable at that same edge. No partial drive.
//  - States: IDLE, GRANT, TURN. All outputs are registered. No combinational path from req to g_.
//  - IDLE: if req!=0, pick the first set bit scanning ptr, ptr+1, ... mod N. At that edge
//    set gnt=onehot(winner), owner=winner, state=GRANT, hold_cnt=1.
//    Latency is 1 clock from req sampled high to g_ low. If req==0, stay in IDLE.
//  - GRANT: while req[owner]=1, hold gnt (hold_cnt saturates at 2**CW-1).
//    If req[owner] is sampled 0: at that edge gnt=0, ptr=(owner+1) mod N, state=TURN, dcnt=0.
//  - TURN: gnt=0. dcnt increments each cycle. After DEAD cycles in TURN, state=IDLE.
//    Total gnt-low gap between two owners = DEAD+1 cycles.
//  - Requests arriving during TURN are not lost. They are arbitrated in IDLE with the updated ptr.
//  - Other req bits changing during GRANT have no effect (no preemption except timeout).
//  - Owner drops req while another bit rises in the same cycle: normal release; new bit waits
//    for IDLE.
//  - Owner re-raises req during TURN: treated as a new request, lowest priority after ptr rotation.
//  - N=1: ptr stays 0. Grant/TURN sequencing is unchanged (dead cycles still inserted).
//  - Invariant: $onehot0(gnt) every cycle, and g_ == ~gnt.
//
// CONFIGURATION
//  BUSARB_TIMEOUT_EN defined:
//    In GRANT, if hold_cnt==MAXHOLD and (req & ~gnt)!=0, force release at that edge, exactly
//    like a req drop: gnt=0, ptr=owner+1, TURN. The owner has held the bus for exactly
//    MAXHOLD cycles. With no other requester pending, the owner keeps the bus with no limit.
//  BUSARB_TIMEOUT_EN undefined:
//    hold_cnt and MAXHOLD are unused. The owner keeps the bus until it drops req.
//
// TESTING  (N=4, DEAD=1, MAXHOLD=4)
//  1. rst=1 for 2 clks, any req -> gnt=0000, g_=1111, busy=0. Reset while gnt=0010 -> next
//     edge gnt=0000, and the following grant starts scanning from requester 0.
//  2. From IDLE, req=0001 -> one edge later gnt=0001, g_=1110, busy=1. Hold 3 clks -> unchanged.
//  3. req=0101 simultaneously from IDLE -> gnt=0001. Drop req[0] -> gnt=0000 for 2 cycles,
//     then gnt=0100, g_=1011.
//  4. req=1111 held, each owner drops its bit for 1 cycle after 2 grant cycles -> grant order
//     0001,0010,0100,1000,0001. Never two bits set. Gap of 2 cycles between grants.
//  5. BUSARB_TIMEOUT_EN, req=0011 held -> gnt=0001 for exactly 4 cycles, 2 idle cycles,
//     then gnt=0010.
//     Same stimulus without the macro -> gnt=0001 persists for 20+ cycles.
//  6. Release req[2] while req[3] rises in the same cycle -> 2-cycle gap, then gnt=1000.
//     Monitor asserts g_==~gnt and $onehot0(gnt) every cycle.

Source files
------------

// File: rtl/bus_drive_arbiter.sv
// Round-robin arbiter for one tristate bus with break-before-make '244 enables.
// Define BUSARB_TIMEOUT_EN to force a release after MAXHOLD cycles when others wait.
module bus_drive_arbiter #(
    parameter int N       = 4,
    parameter int DEAD    = 1,
    parameter int MAXHOLD = 16,
    parameter int CW      = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic [N-1:0] g_,
    output logic         busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = $clog2(DEAD + 1);

    if (2 ** CW <= MAXHOLD) begin : g_cw_check
        $error("CW too narrow to count to MAXHOLD");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_TURN
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_nxt;
    logic [PW-1:0] r_owner;
    logic [PW-1:0] w_owner_nxt;
    logic [PW-1:0] w_owner_inc;
    logic [PW-1:0] w_win;
    logic [DW-1:0] r_dcnt;
    logic [DW-1:0] w_dcnt_nxt;
    logic [N-1:0]  r_gnt;
    logic [N-1:0]  w_gnt_nxt;
    logic [N-1:0]  r_gn;
    logic          r_busy;
    logic [2*N-1:0] w_dbl;
    logic [N-1:0]  w_rot;
    logic [PW:0]   w_sum;
    logic          w_found;
    logic          w_release;
`ifdef BUSARB_TIMEOUT_EN
    logic [CW-1:0] r_hold;
    logic [CW-1:0] w_hold_nxt;
`endif

    // Rotate req so bit i is requester (ptr+i) mod N; first set bit wins.
    always_comb begin
        w_dbl   = {req, req} >> r_ptr;
        w_rot   = w_dbl[N-1:0];
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(i);
            if (w_sum >= (PW+1)'(N)) begin
                w_sum = w_sum - (PW+1)'(N);
            end
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_win   = w_sum[PW-1:0];
            end
        end
    end

    always_comb begin
        w_owner_inc = (r_owner == PW'(N - 1)) ? '0 : r_owner + PW'(1);
        w_release   = !req[r_owner];
`ifdef BUSARB_TIMEOUT_EN
        if ((r_hold == CW'(MAXHOLD)) && (|(req & ~r_gnt))) begin
            w_release = 1'b1;
        end
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_dcnt_nxt  = r_dcnt;
        w_gnt_nxt   = r_gnt;
`ifdef BUSARB_TIMEOUT_EN
        w_hold_nxt  = r_hold;
`endif
        unique case (r_state)
            S_IDLE: begin
                w_gnt_nxt = '0;
                if (w_found) begin
                    w_state_nxt = S_GRANT;
                    w_owner_nxt = w_win;
                    w_gnt_nxt   = N'(1) << w_win;
`ifdef BUSARB_TIMEOUT_EN
                    w_hold_nxt  = CW'(1);
`endif
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    w_state_nxt = S_TURN;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = w_owner_inc;
                    w_dcnt_nxt  = '0;
                end
`ifdef BUSARB_TIMEOUT_EN
                else if (r_hold != '1) begin
                    w_hold_nxt = r_hold + CW'(1);
                end
`endif
            end
            S_TURN: begin
                w_gnt_nxt = '0;
                if (r_dcnt == DW'(DEAD - 1)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_dcnt_nxt = r_dcnt + DW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_dcnt  <= '0;
            r_gnt   <= '0;
            r_gn    <= '1;
            r_busy  <= 1'b0;
`ifdef BUSARB_TIMEOUT_EN
            r_hold  <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_gn    <= ~w_gnt_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
`ifdef BUSARB_TIMEOUT_EN
            r_hold  <= w_hold_nxt;
`endif
        end
    end

    assign gnt  = r_gnt;
    assign g_   = r_gn;
    assign busy = r_busy;

endmodule

// File: tb/tb_bus_drive_arbiter.sv
// Directed and random checks of bus_drive_arbiter against a cycle-level bus-ownership model.
// Honours BUSARB_TIMEOUT_EN the same way as the design.
module tb_bus_drive_arbiter;

    localparam int N       = 4;
    localparam int DEAD    = 1;
    localparam int MAXHOLD = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt;
    logic [N-1:0] g_;
    logic         busy;

    int errors = 0;
    int checks = 0;

    // Ownership model: who holds the bus, how long, and quiet cycles left.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_quiet = 0;
    int m_held  = 0;

    bus_drive_arbiter #(
        .N(N), .DEAD(DEAD), .MAXHOLD(MAXHOLD), .CW(5)
    ) dut (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt), .g_(g_), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        checks++;
        assert ((g_ === ~gnt) && $onehot0(gnt)) else begin
            errors++;
            $error("FAIL monitor: observed gnt=%b g_=%b expected onehot0 gnt and g_=~gnt",
                   gnt, g_);
        end
    end

    task automatic model_edge(input logic rs, input logic [N-1:0] r);
        bit others;
        bit tmo;
        others = 1'b0;
        tmo    = 1'b0;
        if (rs) begin
            m_owner = -1;
            m_ptr   = 0;
            m_quiet = 0;
            m_held  = 0;
        end else if (m_owner >= 0) begin
            for (int i = 0; i < N; i++) begin
                if (i != m_owner && r[i]) others = 1'b1;
            end
`ifdef BUSARB_TIMEOUT_EN
            tmo = (m_held == MAXHOLD) && others;
`endif
            if (!r[m_owner] || tmo) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_quiet = DEAD;
            end else begin
                m_held++;
            end
        end else if (m_quiet > 0) begin
            m_quiet--;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_owner < 0 && r[(m_ptr + i) % N]) begin
                    m_owner = (m_ptr + i) % N;
                    m_held  = 1;
                end
            end
        end
    endtask

    function automatic logic [N-1:0] m_gnt();
        return (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    endfunction

    task automatic chk(input string tag, input logic [N-1:0] obs,
                       input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic rs = 1'b0);
        req = r;
        rst = rs;
        @(posedge clk);
        model_edge(rs, r);
        #1;
        chk("model_gnt", gnt, m_gnt());
        chk("model_g_", g_, ~m_gnt());
        chk("model_busy", N'(busy), N'((m_owner >= 0) || (m_quiet > 0)));
    endtask

    initial begin
        logic [N-1:0] e;
        logic [N-1:0] r;
        int n;
        int z;

        // Reset holds everything off regardless of requests
        step(4'hF, 1'b1);
        step(4'hF, 1'b1);
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_g_", g_, 4'b1111);
        chk("rst_busy", N'(busy), 4'b0000);
        step(4'b0010);
        chk("pre_rst_gnt", gnt, 4'b0010);
        step(4'hF, 1'b1);
        chk("rst_drop_gnt", gnt, 4'b0000);
        step(4'hF);
        chk("rst_ptr_gnt", gnt, 4'b0001);

        // Single requester, 1-cycle latency, then held
        step(4'b0000, 1'b1);
        step(4'b0001);
        chk("t2_gnt", gnt, 4'b0001);
        chk("t2_g_", g_, 4'b1110);
        chk("t2_busy", N'(busy), 4'b0001);
        for (int i = 0; i < 3; i++) begin
            step(4'b0001);
            chk("t2_hold", gnt, 4'b0001);
        end

        // Two requesters, drop owner, 2-cycle gap
        step(4'b0000, 1'b1);
        step(4'b0101);
        chk("t3_first", gnt, 4'b0001);
        step(4'b0100);
        chk("t3_gap1", gnt, 4'b0000);
        step(4'b0100);
        chk("t3_gap2", gnt, 4'b0000);
        step(4'b0100);
        chk("t3_next", gnt, 4'b0100);
        chk("t3_g_", g_, 4'b1011);

        // All requesting, each owner drops briefly: strict rotation
        step(4'b0000, 1'b1);
        for (int k = 0; k < 5; k++) begin
            e = N'(1) << (k % N);
            n = 0;
            step(4'hF);
            while (gnt == '0 && n < 8) begin
                n++;
                step(4'hF);
            end
            chk("t4_order", gnt, e);
            if (k > 0) chk("t4_gap", N'(n + 1), 4'd2);
            step(4'hF);
            step(4'hF & ~e);
        end

        // Persistent owner with another waiter
        step(4'b0000, 1'b1);
        step(4'b0011);
        chk("t5_first", gnt, 4'b0001);
`ifdef BUSARB_TIMEOUT_EN
        n = 1;
        while (gnt == 4'b0001 && n < 30) begin
            step(4'b0011);
            if (gnt == 4'b0001) n++;
        end
        chk("t5_hold_len", N'(n), N'(MAXHOLD));
        z = 1;
        while (gnt == '0 && z < 10) begin
            step(4'b0011);
            if (gnt == '0) z++;
        end
        chk("t5_gap", N'(z), 4'd2);
        chk("t5_next", gnt, 4'b0010);
`else
        for (int i = 0; i < 22; i++) begin
            step(4'b0011);
            chk("t5_persist", gnt, 4'b0001);
        end
`endif

        // Owner releases as another raises in the same cycle
        step(4'b0000, 1'b1);
        step(4'b0100);
        chk("t6_first", gnt, 4'b0100);
        step(4'b0100);
        step(4'b1000);
        chk("t6_gap1", gnt, 4'b0000);
        step(4'b1000);
        chk("t6_gap2", gnt, 4'b0000);
        step(4'b1000);
        chk("t6_next", gnt, 4'b1000);

        // Random traffic against the model
        r = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom);
            step(r, ($urandom_range(0, 99) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
